// File: rtl/ahb_burst_addr_gen_pkg.sv
// Shared types and helpers for the AHB burst address generator.
// Consumers: ahb_burst_decode, ahb_burst_addr_gen.
package ahb_burst_pkg;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    SIZE_BYTE = 3'd0,
    SIZE_HALF = 3'd1,
    SIZE_WORD = 3'd2,
    SIZE_DW   = 3'd3,
    SIZE_4W   = 3'd4,
    SIZE_8W   = 3'd5,
    SIZE_16W  = 3'd6,
    SIZE_32W  = 3'd7
  } hsize_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int BOUNDARY_1KB = 10;

  // Zero means unbounded (plain INCR).
  function automatic logic [4:0] burst_beats(input hburst_e hb);
    logic [4:0] n;
    unique case (hb)
      SINGLE:         n = 5'd1;
      WRAP4, INCR4:   n = 5'd4;
      WRAP8, INCR8:   n = 5'd8;
      WRAP16, INCR16: n = 5'd16;
      default:        n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] burst_onehot(input hburst_e hb);
    return 8'd1 << hb;
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen_decode.sv
// HBURST decoder: beat count, wrap flag and one-hot behaviour.
// Purely combinational.
module ahb_burst_decode
  import ahb_burst_pkg::*;
(
  input  logic [2:0] hburst_i,
  output logic [4:0] beats_o,
  output logic       wrap_o,
  output logic [7:0] onehot_o
);

  hburst_e hb;

  assign hb = hburst_e'(hburst_i);

  always_comb begin
    beats_o  = burst_beats(hb);
    onehot_o = burst_onehot(hb);
    unique case (hb)
      WRAP4, WRAP8, WRAP16: wrap_o = 1'b1;
      default:              wrap_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// AHB burst address generator (INCR/WRAP beats, count, done/err).
// Define AHB_1KB_BOUNDARY_EN to enable the sticky 1 KB crossing flag.
module ahb_burst_addr_gen
  import ahb_burst_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [2:0]        HBURST,
  input  logic [2:0]        HSIZE,
  input  logic              advance,
  input  logic              stop,
  output logic [ADDR_W-1:0] addr_out,
  output logic [4:0]        beat_cnt,
  output logic              busy,
  output logic              last_beat,
  output logic              done,
  output logic              err,
  output logic [7:0]        SIGNAL_BEHAVIOR,
  output logic              bound_err
);

  localparam logic [2:0] MAX_SZ = 3'($clog2(DATA_W / 8));

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        cnt_q;
  logic [2:0]        hb_q;
  hsize_e            sz_q;
  logic              last_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        beh_q;

  logic [4:0]        dec_beats;
  logic              dec_wrap;
  logic [7:0]        dec_onehot;

  ahb_burst_decode u_dec (
    .hburst_i (hb_q),
    .beats_o  (dec_beats),
    .wrap_o   (dec_wrap),
    .onehot_o (dec_onehot)
  );

  logic [ADDR_W-1:0] amask;
  logic              size_ok;
  logic              align_ok;
  logic              accept;
  logic              reject;
  logic              step;
  logic              fin;

  assign amask    = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
  assign size_ok  = HSIZE <= MAX_SZ;
  assign align_ok = (HADDR & amask) == '0;

  assign accept = (state_q == ST_IDLE) && start
                && size_ok && align_ok;
  assign reject = (state_q == ST_IDLE) && start
                && !(size_ok && align_ok);
  assign step   = (state_q == ST_BURST) && !stop
                && advance && !last_q;
  assign fin    = (state_q == ST_BURST)
                && (stop || (advance && last_q));

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] wmask;
  logic [ADDR_W-1:0] stepped;
  logic [ADDR_W-1:0] addr_nxt;
  logic [4:0]        cnt_nxt;
  logic              last_nxt;

  assign inc     = ADDR_W'(1) << sz_q;
  assign wmask   = (ADDR_W'(dec_beats) << sz_q)
                 - ADDR_W'(1);
  assign stepped = addr_q + inc;

  // Wrap keeps the block base, only the offset rolls over.
  assign addr_nxt = dec_wrap
                  ? ((addr_q & ~wmask) | (stepped & wmask))
                  : stepped;

  assign cnt_nxt  = (cnt_q == 5'd31) ? cnt_q
                                     : cnt_q + 5'd1;
  assign last_nxt = (dec_beats != 5'd0)
                 && (cnt_nxt == dec_beats - 5'd1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      hb_q    <= '0;
      sz_q    <= SIZE_BYTE;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      beh_q   <= '0;
    end else begin
      done_q <= fin;
      err_q  <= reject;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_BURST;
            addr_q  <= HADDR;
            cnt_q   <= '0;
            hb_q    <= HBURST;
            sz_q    <= hsize_e'(HSIZE);
            last_q  <= HBURST == SINGLE;
            beh_q   <= burst_onehot(hburst_e'(HBURST));
          end
        end
        ST_BURST: begin
          if (fin) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
            beh_q   <= '0;
          end else begin
            beh_q <= dec_onehot;
            if (step) begin
              addr_q <= addr_nxt;
              cnt_q  <= cnt_nxt;
              last_q <= last_nxt;
            end
          end
        end
      endcase
    end
  end

`ifdef AHB_1KB_BOUNDARY_EN
  logic bound_q;
  logic cross;

  assign cross = !dec_wrap
    && (addr_nxt[ADDR_W-1:BOUNDARY_1KB]
        != addr_q[ADDR_W-1:BOUNDARY_1KB]);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bound_q <= 1'b0;
    end else if (accept) begin
      bound_q <= 1'b0;
    end else if (step && cross) begin
      bound_q <= 1'b1;
    end
  end

  assign bound_err = bound_q;
`else
  assign bound_err = 1'b0;
`endif

  assign addr_out        = addr_q;
  assign beat_cnt        = cnt_q;
  assign busy            = state_q == ST_BURST;
  assign last_beat       = last_q;
  assign done            = done_q;
  assign err             = err_q;
  assign SIGNAL_BEHAVIOR = beh_q;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Testbench for ahb_burst_addr_gen: directed plan cases plus
// randomized bursts against a closed-form address model.
module tb_ahb_burst_addr_gen;

`ifdef AHB_1KB_BOUNDARY_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] HADDR = '0;
  logic [2:0]  HBURST = '0;
  logic [2:0]  HSIZE = '0;
  logic        advance = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] addr_out;
  logic [4:0]  beat_cnt;
  logic        busy, last_beat, done, err, bound_err;
  logic [7:0]  SIGNAL_BEHAVIOR;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_addr;
  int          m_cnt;
  bit          m_bound;

  ahb_burst_addr_gen #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .start           (start),
    .HADDR           (HADDR),
    .HBURST          (HBURST),
    .HSIZE           (HSIZE),
    .advance         (advance),
    .stop            (stop),
    .addr_out        (addr_out),
    .beat_cnt        (beat_cnt),
    .busy            (busy),
    .last_beat       (last_beat),
    .done            (done),
    .err             (err),
    .SIGNAL_BEHAVIOR (SIGNAL_BEHAVIOR),
    .bound_err       (bound_err)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [49:0] obs();
    return {addr_out, beat_cnt, busy, last_beat,
            done, err, SIGNAL_BEHAVIOR, bound_err};
  endfunction

  function automatic logic [49:0] ex(
    input logic [31:0] a, input int c,
    input bit b, input bit l, input bit d, input bit e,
    input logic [7:0] bh, input bit bd);
    return {a, 5'(c), b, l, d, e, bh, bd};
  endfunction

  function automatic int beats_of(input int hb);
    int n;
    case (hb)
      0: n = 1;
      1: n = 0;
      2, 3: n = 4;
      4, 5: n = 8;
      default: n = 16;
    endcase
    return n;
  endfunction

  function automatic bit is_wrap(input int hb);
    return (hb == 2) || (hb == 4) || (hb == 6);
  endfunction

  // Address of beat i from the first address and burst rules.
  function automatic logic [31:0] beat_addr(
    input logic [31:0] a0, input int hb,
    input int sz, input int i);
    longint unsigned size, blk, base, off;
    size = longint'(1) << sz;
    if (is_wrap(hb)) begin
      blk  = longint'(beats_of(hb)) * size;
      base = a0 - (a0 % blk);
      off  = (a0 - base + longint'(i) * size) % blk;
      return 32'(base + off);
    end
    return 32'(longint'(a0) + longint'(i) * size);
  endfunction

  task automatic test_reset;
    logic [49:0] x;
    HRESETn = 1'b0;
    tick();
    x = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL reset obs=%h exp=%h", obs(), x);
    end
    HRESETn = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL reset_release obs=%h exp=%h", obs(), x);
    end
  endtask

  task automatic test_reject;
    logic [49:0] x;
    HADDR = 32'h0; HBURST = 3'd3; HSIZE = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = ex(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL reject_size obs=%h exp=%h", obs(), x);
    end
    tick();
    x = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL reject_pulse obs=%h exp=%h", obs(), x);
    end
    HADDR = 32'h2; HSIZE = 3'd2;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      x = ex(0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL reject_align%0d obs=%h exp=%h",
                 k, obs(), x);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_wrap4;
    logic [49:0] x;
    logic [31:0] tab [4];
    tab = '{32'h38, 32'h3C, 32'h30, 32'h34};
    HADDR = 32'h38; HBURST = 3'd2; HSIZE = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      x = ex(tab[k], k, 1, k == 3, 0, 0, 8'h04, 0);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL wrap4_beat%0d obs=%h exp=%h",
                 k, obs(), x);
      end
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    x = ex(32'h34, 3, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL wrap4_done obs=%h exp=%h", obs(), x);
    end
    tick();
    x = ex(32'h34, 3, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL wrap4_idle obs=%h exp=%h", obs(), x);
    end
  endtask

  task automatic test_incr8;
    logic [49:0] x;
    HADDR = 32'h100; HBURST = 3'd5; HSIZE = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      x = ex(32'h100 + 2 * k, k, 1, k == 7, 0, 0, 8'h20, 0);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL incr8_beat%0d obs=%h exp=%h",
                 k, obs(), x);
      end
      if (k == 3) begin
        tick();
        checks++;
        if (obs() !== x) begin
          errors++;
          $display("FAIL incr8_hold obs=%h exp=%h", obs(), x);
        end
      end
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    x = ex(32'h10E, 7, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL incr8_done obs=%h exp=%h", obs(), x);
    end
    tick();
  endtask

  task automatic test_incr_boundary;
    logic [49:0] x;
    logic [31:0] tab [3];
    tab = '{32'h3FE, 32'h3FF, 32'h400};
    HADDR = 32'h3FE; HBURST = 3'd1; HSIZE = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = ex(tab[k], k, 1, 0, 0, 0, 8'h02, BEN && k == 2);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL incr_bnd_beat%0d obs=%h exp=%h",
                 k, obs(), x);
      end
      if (k < 2) begin
        advance = 1'b1;
        tick();
        advance = 1'b0;
      end
    end
    advance = 1'b1; stop = 1'b1;
    tick();
    advance = 1'b0; stop = 1'b0;
    x = ex(32'h400, 2, 0, 0, 1, 0, 0, BEN);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL incr_bnd_stop obs=%h exp=%h", obs(), x);
    end
    tick();
    x = ex(32'h400, 2, 0, 0, 0, 0, 0, BEN);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL incr_bnd_idle obs=%h exp=%h", obs(), x);
    end
  endtask

  task automatic test_single;
    logic [49:0] x;
    HADDR = 32'h20; HBURST = 3'd0; HSIZE = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = ex(32'h20, 0, 1, 1, 0, 0, 8'h01, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL single_beat obs=%h exp=%h", obs(), x);
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    x = ex(32'h20, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL single_done obs=%h exp=%h", obs(), x);
    end
    tick();
  endtask

  task automatic test_busy_start;
    logic [49:0] x;
    logic [31:0] tab [4];
    tab = '{32'h85, 32'h86, 32'h87, 32'h80};
    HADDR = 32'h85; HBURST = 3'd4; HSIZE = 3'd0;
    start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      x = ex(tab[k], k, 1, 0, 0, 0, 8'h10, 0);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL busy_start%0d obs=%h exp=%h",
                 k, obs(), x);
      end
      if (k < 3) begin
        HADDR = 32'h500; HBURST = 3'd7; HSIZE = 3'd3;
        advance = 1'b1;
        tick();
        advance = 1'b0;
      end
    end
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    x = ex(32'h80, 3, 0, 0, 1, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL busy_stop obs=%h exp=%h", obs(), x);
    end
    tick();
  endtask

  task automatic test_reset_midburst;
    logic [49:0] x;
    HADDR = 32'h40; HBURST = 3'd6; HSIZE = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    x = ex(32'h54, 5, 1, 0, 0, 0, 8'h40, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL wrap16_mid obs=%h exp=%h", obs(), x);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    x = ex(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL async_reset obs=%h exp=%h", obs(), x);
    end
    tick();
    HRESETn = 1'b1;
    tick();
    HADDR = 32'h1000; HBURST = 3'd3; HSIZE = 3'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = ex(32'h1000, 0, 1, 0, 0, 0, 8'h08, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL post_reset_start obs=%h exp=%h", obs(), x);
    end
    advance = 1'b1;
    tick();
    advance = 1'b0;
    x = ex(32'h1004, 1, 1, 0, 0, 0, 8'h08, 0);
    checks++;
    if (obs() !== x) begin
      errors++;
      $display("FAIL post_reset_adv obs=%h exp=%h", obs(), x);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_random;
    logic [49:0] x;
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    m_addr = '0; m_cnt = 0; m_bound = 1'b0;
    for (int b = 0; b < 60; b++) begin
      int hb, sz, n, i, lim;
      bit wr, rej, ended, dn, adv, stp;
      logic [31:0] a0, a, ap;
      hb = $urandom_range(0, 7);
      sz = $urandom_range(0, 3);
      a0 = $urandom;
      if ($urandom_range(0, 1) == 1)
        a0[9:0] = 10'($urandom_range(960, 1023));
      a0 = a0 & ~((32'd1 << sz) - 32'd1);
      if (sz > 0 && $urandom_range(0, 7) == 0) a0[0] = 1'b1;
      rej = (sz > 2) || ((a0 & ((32'd1 << sz) - 32'd1)) != 0);
      HADDR = a0; HBURST = 3'(hb); HSIZE = 3'(sz);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (rej) begin
        x = ex(m_addr, m_cnt, 0, 0, 0, 1, 0, BEN && m_bound);
        checks++;
        if (obs() !== x) begin
          errors++;
          $display("FAIL rnd_reject b%0d obs=%h exp=%h",
                   b, obs(), x);
        end
        tick();
        continue;
      end
      n = beats_of(hb);
      wr = is_wrap(hb);
      lim = $urandom_range(0, 36);
      i = 0; ended = 1'b0; m_bound = 1'b0;
      x = ex(a0, 0, 1, n == 1, 0, 0, 8'(1 << hb), 0);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL rnd_start b%0d obs=%h exp=%h",
                 b, obs(), x);
      end
      for (int c = 0; c < 200 && !ended; c++) begin
        adv = $urandom_range(0, 3) != 0;
        if (n == 0) stp = (i >= lim) && ($urandom_range(0, 1) == 1);
        else stp = $urandom_range(0, 24) == 0;
        if (c == 199) stp = 1'b1;
        advance = adv; stop = stp;
        tick();
        advance = 1'b0; stop = 1'b0;
        dn = 1'b0;
        if (stp) begin
          ended = 1'b1; dn = 1'b1;
        end else if (adv) begin
          if (n != 0 && i == n - 1) begin
            ended = 1'b1; dn = 1'b1;
          end else begin
            ap = beat_addr(a0, hb, sz, i);
            a = beat_addr(a0, hb, sz, i + 1);
            if (!wr && (a >> 10) != (ap >> 10)) m_bound = 1'b1;
            i++;
          end
        end
        x = ex(beat_addr(a0, hb, sz, i), (i > 31) ? 31 : i,
               !ended, !ended && n != 0 && i == n - 1, dn, 0,
               ended ? 8'h00 : 8'(1 << hb), BEN && m_bound);
        checks++;
        if (obs() !== x) begin
          errors++;
          $display("FAIL rnd_beat b%0d c%0d obs=%h exp=%h",
                   b, c, obs(), x);
        end
      end
      m_addr = beat_addr(a0, hb, sz, i);
      m_cnt = (i > 31) ? 31 : i;
      tick();
      x = ex(m_addr, m_cnt, 0, 0, 0, 0, 0, BEN && m_bound);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL rnd_idle b%0d obs=%h exp=%h",
                 b, obs(), x);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reject();
    test_wrap4();
    test_incr8();
    test_incr_boundary();
    test_single();
    test_busy_start();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
